core_ctrl_fsm: RTL

CORE_CTRL_FSM -- requirements
Module: core_ctrl_fsm

---
 rtl/riscv_defs.sv | 31 +++
 rtl/core_perf_cnt.sv | 40 ++++
 rtl/core_ctrl_fsm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riscv_defs                                                       |
// | Purpose : Shared control-path types for the core: PC source select and     |
// |           the control FSM state encoding, plus the wait-counter width.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package riscv_defs;

  // Next-PC source chosen by the datapath when pc_we is asserted.
  typedef enum logic [1:0] {
    PC_PLUS_4 = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_sel_t;

  // Multi-cycle control FSM states (exported on the debug port).
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } ctrl_state_t;

  // Width of the memory-ack wait counter; TIMEOUT_CYCLES must fit in it.
  localparam int unsigned WAIT_CNT_W = 8;

endpackage : riscv_defs
`default_nettype wire

// File: rtl/core_perf_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : core_perf_cnt                                                    |
// | Purpose : Free-running cycle counter and retired-instruction counter.      |
// |           Only instantiated when CORE_CTRL_PERF_EN is defined.             |
// | Ports   : clk         - core clock                                         |
// |           rst         - synchronous active-high reset, clears both counts  |
// |           retire      - one-cycle pulse per retired instruction            |
// |           cycle_cnt   - cycles since reset, wraps at 2^32                  |
// |           instret_cnt - retired instructions since reset, wraps at 2^32    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module core_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (retire) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule : core_perf_cnt
`default_nettype wire

// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : core_ctrl_fsm                                                    |
// | Purpose : Multi-cycle control FSM for a simple RISC-V core:                |
// |           FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a memory-ack        |
// |           timeout and an absorbing TRAP state.                             |
// | Config  : CORE_CTRL_PERF_EN - adds cycle_cnt / instret_cnt outputs backed  |
// |           by core_perf_cnt. Undefined by default.                          |
// | Ports   : clk, rst (sync, active-high)                                     |
// |           imem_req/imem_ack, ir_we           - instruction fetch          |
// |           dec_*                              - decoder flags for the IR    |
// |           alu_zero                           - branch condition            |
// |           dmem_req/dmem_we/dmem_ack          - data memory handshake       |
// |           pc_we/pc_sel/rf_we                 - datapath strobes            |
// |           halted, state                      - trap flag, debug view       |
// |           cycle_cnt, instret_cnt             - perf counters (optional)    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module core_ctrl_fsm
  import riscv_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        dec_valid,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_branch,
  input  logic        dec_is_jump,
  input  logic        dec_writes_rd,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output pc_sel_t     pc_sel,
  output logic        rf_we,
  output logic        halted,
  output ctrl_state_t state
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] c_timeout = TIMEOUT_CYCLES[WAIT_CNT_W-1:0];

  ctrl_state_t           r_state;
  ctrl_state_t           w_state_next;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
  logic [WAIT_CNT_W-1:0] w_wait_inc;
  logic                  w_timeout;
  // High for the cycle(s) after a reset edge. Keeps every strobe low and the
  // FSM parked in FETCH until reset has been released for a full edge, so the
  // first fetch request appears in the cycle after rst deasserts.
  logic                  r_hold;

  // A non-ack cycle that brings the counter up to the limit is the last one
  // allowed; an ack in that same cycle is checked first and wins.
  assign w_wait_inc = r_wait_cnt + WAIT_CNT_W'(1);
  assign w_timeout  = (w_wait_inc >= c_timeout);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_hold     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_hold     <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The wait counter defaults to zero so it is clear on
  // every entry into FETCH or MEM; it only accumulates while waiting.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = '0;
    if (!r_hold) begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            w_state_next = S_DECODE;
          end else if (w_timeout) begin
            w_state_next = S_TRAP;
          end else begin
            w_wait_cnt_next = w_wait_inc;
          end
        end
        S_DECODE: begin
          w_state_next = dec_valid ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          w_state_next = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ack) begin
            w_state_next = S_WB;
          end else if (w_timeout) begin
            w_state_next = S_TRAP;
          end else begin
            w_wait_cnt_next = w_wait_inc;
          end
        end
        S_WB: begin
          w_state_next = S_FETCH;
        end
        S_TRAP: begin
          w_state_next = S_TRAP;
        end
        default: begin
          // Unused encodings are treated as a fault.
          w_state_next = S_TRAP;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS_4;
    rf_we    = 1'b0;
    halted   = 1'b0;
    if (!r_hold) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_is_store;
        end
        S_WB: begin
          pc_we = 1'b1;
          // A store never writes the register file, whatever the decoder says.
          rf_we = dec_writes_rd && !dec_is_store;
          if (dec_is_jump) begin
            pc_sel = PC_JUMP;
          end else if (dec_is_branch && alu_zero) begin
            pc_sel = PC_BRANCH;
          end
        end
        S_TRAP: begin
          halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state = r_state;

`ifdef CORE_CTRL_PERF_EN
  // Every WB cycle retires exactly one instruction, marked by pc_we.
  core_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .retire      (pc_we),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule : core_ctrl_fsm
`default_nettype wire
